// File: rtl/serializador.sv
// Transmit side of the bit-serial link: a one-word holding buffer feeding an LSB-first
// shifter, one bit per clock with a write strobe, stalled by the downstream status.
module serializador #(
  parameter int WIDTH = 8
) (
  input  logic             clock_100KHz,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             ready_out,
  output logic             data_out,
  output logic             write_out,
  input  logic             status_in,
  output logic             busy_out,
  output logic [7:0]       words_sent
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] shifter_q, shifter_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             data_out_q, data_out_d;
  logic             write_out_q, write_out_d;
  logic [7:0]       words_sent_q, words_sent_d;
  logic             accept, transfer;

  // Producer handshake is independent of the downstream status.
  assign accept = data_valid && !hold_full_q;

  always_ff @(posedge clock_100KHz or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      shifter_q    <= '0;
      bit_cnt_q    <= '0;
      data_out_q   <= 1'b0;
      write_out_q  <= 1'b0;
      words_sent_q <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      shifter_q    <= shifter_d;
      bit_cnt_q    <= bit_cnt_d;
      data_out_q   <= data_out_d;
      write_out_q  <= write_out_d;
      words_sent_q <= words_sent_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    shifter_d    = shifter_q;
    bit_cnt_d    = bit_cnt_q;
    data_out_d   = data_out_q;
    write_out_d  = 1'b0;
    words_sent_d = words_sent_q;
    transfer     = 1'b0;

    case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          transfer = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        // A stall freezes shifter, count and data_out so no bit is lost or repeated.
        if (status_in) begin
          data_out_d  = shifter_q[0];
          write_out_d = 1'b1;
          shifter_d   = shifter_q >> 1;
          bit_cnt_d   = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            state_d      = GAP;
            words_sent_d = words_sent_q + 8'd1;
          end
        end
      end
      GAP: begin
        // One quiet cycle lets the registered downstream status catch up.
        if (hold_full_q) begin
          transfer = 1'b1;
          state_d  = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (transfer) begin
      shifter_d   = hold_q;
      bit_cnt_d   = '0;
      hold_full_d = 1'b0;
    end
    // Accept last so a same-edge refill keeps the buffer full.
    if (accept) begin
      hold_d      = data_in;
      hold_full_d = 1'b1;
    end
  end

  assign ready_out  = !hold_full_q;
  assign data_out   = data_out_q;
  assign write_out  = write_out_q;
  assign busy_out   = (state_q != IDLE) || hold_full_q;
  assign words_sent = words_sent_q;

endmodule

// File: tb/tb_serializador.sv
// Directed bench for serializador: stimulus pushes expected words into a queue, a negedge
// monitor deserializes the strobed bits and compares against the queue.
module tb_serializador;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       data_valid;
  logic       ready_out;
  logic       data_out;
  logic       write_out;
  logic       status_in;
  logic       busy_out;
  logic [7:0] words_sent;

  serializador #(.WIDTH(8)) dut (
    .clock_100KHz(clk),
    .reset       (reset),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .ready_out   (ready_out),
    .data_out    (data_out),
    .write_out   (write_out),
    .status_in   (status_in),
    .busy_out    (busy_out),
    .words_sent  (words_sent)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] exp_q[$];
  logic       st_edge = 1'b1;
  int         rx_cnt = 0;
  logic [7:0] rx_w = '0;
  logic       gap_chk = 1'b0;
  int         last_start = 0, last_end = 0, prev_end = 0;
  int         acc_cyc = 0;
  logic [7:0] prev_ws = '0;
  logic       saw_wrap = 1'b0;
  bit         done6 = 1'b0;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    st_edge <= status_in;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: outputs are stable at negedge, half a period from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      rx_cnt  = 0;
      gap_chk = 1'b0;
    end else begin
      if (prev_ws == 8'hFF && words_sent == 8'h00) saw_wrap = 1'b1;
      prev_ws = words_sent;
      if (gap_chk) begin
        gap_chk = 1'b0;
        checks++;
        if (write_out) begin
          errors++;
          $display("FAIL gap_after_word got write_out=1 expected 0");
        end
      end
      if (write_out) begin
        checks++;
        if (!st_edge) begin
          errors++;
          $display("FAIL strobe_during_stall got write_out=1 expected 0");
        end
        if (rx_cnt == 0) begin
          prev_end   = last_end;
          last_start = cyc;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe got strobe expected none");
          end
        end
        rx_w = {data_out, rx_w[7:1]};
        rx_cnt++;
        if (rx_cnt == 8) begin
          rx_cnt   = 0;
          last_end = cyc;
          gap_chk  = 1'b1;
          if (exp_q.size() != 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            checks++;
            if (rx_w !== e) begin
              errors++;
              $display("FAIL rx_word got %0h expected %0h", rx_w, e);
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] w);
    int   t = 0;
    logic r;
    data_in    = w;
    data_valid = 1'b1;
    do begin
      r = ready_out;
      tick();
      t++;
    end while (!r && t < 1000);
    data_valid = 1'b0;
    data_in    = 8'($urandom);
    if (!r) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got ready_out=0 expected 1");
    end else begin
      exp_q.push_back(w);
      acc_cyc = cyc;
    end
  endtask

  task automatic wait_done();
    int t = 0;
    while ((busy_out || exp_q.size() != 0 || rx_cnt != 0) && t < 3000) begin
      tick();
      t++;
    end
    if (t >= 3000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got busy_out=%0d expected 0", busy_out);
    end
  endtask

  initial begin
    int n;
    // 1: reset with random inputs
    reset      = 1'b1;
    status_in  = 1'b1;
    data_valid = 1'b0;
    data_in    = '0;
    for (int i = 0; i < 4; i++) begin
      data_in    = 8'($urandom);
      data_valid = 1'($urandom);
      status_in  = 1'($urandom);
      tick();
    end
    chk("rst_write_out", write_out, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_ready_out", ready_out, 1);
    chk("rst_busy_out", busy_out, 0);
    chk("rst_words_sent", words_sent, 0);
    data_valid = 1'b0;
    status_in  = 1'b1;
    reset      = 1'b0;
    tick();

    // 2: single word, latency and completion
    send(8'hA5);
    wait_done();
    chk("a5_first_bit_latency", last_start - acc_cyc, 2);
    chk("a5_last_bit_latency", last_end - acc_cyc, 9);
    chk("a5_words_sent", words_sent, 1);
    chk("a5_busy_idle", busy_out, 0);

    // 3: back-to-back, second word accepted mid-shift
    send(8'h3C);
    send(8'hC3);
    chk("b2b_accept_mid_shift", busy_out, 1);
    wait_done();
    chk("b2b_one_gap_cycle", last_start - prev_end, 2);
    chk("b2b_words_sent", words_sent, 3);

    // 4: stall after bit 3 for 5 cycles
    send(8'hF0);
    n = 0;
    for (int t = 0; t < 50 && n < 4; t++) begin
      tick();
      if (write_out) n++;
    end
    chk("f0_bits_before_stall", n, 4);
    status_in = 1'b0;
    n = 0;
    for (int t = 0; t < 5; t++) begin
      tick();
      if (write_out) n++;
    end
    chk("f0_no_strobe_in_stall", n, 0);
    status_in = 1'b1;
    wait_done();
    chk("f0_words_sent", words_sent, 4);

    // 5: reset mid-word
    send(8'h81);
    n = 0;
    for (int t = 0; t < 50 && n < 5; t++) begin
      tick();
      if (write_out) n++;
    end
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_write_out", write_out, 0);
    chk("mid_rst_data_out", data_out, 0);
    chk("mid_rst_ready_out", ready_out, 1);
    chk("mid_rst_busy_out", busy_out, 0);
    chk("mid_rst_words_sent", words_sent, 0);
    exp_q.delete();
    tick();
    tick();
    reset = 1'b0;
    n = 0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (write_out) n++;
    end
    chk("post_rst_no_strobes", n, 0);
    chk("post_rst_busy", busy_out, 0);
    send(8'h55);
    wait_done();
    chk("post_rst_55_words_sent", words_sent, 1);

    // 6: 256 random words with random stalls
    fork
      begin
        for (int i = 0; i < 256; i++) begin
          for (int k = $urandom_range(0, 2); k > 0; k--) tick();
          send(8'($urandom));
        end
        done6 = 1'b1;
      end
      begin
        while (!done6) begin
          tick();
          status_in = ($urandom_range(0, 3) != 0);
        end
        status_in = 1'b1;
      end
    join
    wait_done();
    chk("rand_words_sent_wrapped", words_sent, 1);
    chk("rand_saw_wrap_to_zero", saw_wrap, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
